// File: rtl/wfifo_wr_front.sv
// Write-domain front end of the async FIFO: 2-entry skid buffer feeding winc/wdata,
// plus registered fill level / almost-full. Optional counters under `WFRONT_STATS_EN.
module wfifo_wr_front #(
   parameter int DSIZE     = 8,
   parameter int ADDRSIZE  = 4,
   parameter int AF_THRESH = 12
) (
   input  logic                wclk,
   input  logic                wrst_n,
   input  logic                s_valid,
   input  logic [DSIZE-1:0]    s_data,
   output logic                s_ready,
   input  logic                wfull,
   input  logic [ADDRSIZE:0]   wptr,
   input  logic [ADDRSIZE:0]   wq2_rptr,
   output logic                winc,
   output logic [DSIZE-1:0]    wdata,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                walmost_full,
   output logic [15:0]         stall_cnt,
   output logic [15:0]         wr_cnt
);

   localparam int PW = ADDRSIZE + 1;
   localparam logic [PW-1:0] AF_LIM = PW'(AF_THRESH);

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // ---------------- skid buffer ----------------
   logic [1:0][DSIZE-1:0] slot;
   logic                  head, tail;
   logic [1:0]            cnt, cnt_next;
   logic                  accept;

   assign accept = s_valid & s_ready;
   assign winc   = (cnt != 2'd0) & ~wfull;
   assign wdata  = slot[head];

   // NOTE: cnt_next gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_next = cnt;
      case ({accept, winc})
         2'b10:   cnt_next = cnt + 2'd1;
         2'b01:   cnt_next = cnt - 2'd1;
         default: cnt_next = cnt;
      endcase
   end

   // NOTE: the two slots are reset because wdata must read 0 out of reset; with only
   // two entries that costs nothing, unlike resetting a real memory array.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         slot    <= '0;
         head    <= 1'b0;
         tail    <= 1'b0;
         cnt     <= 2'd0;
         s_ready <= 1'b0;
      end else begin
         if (accept) begin
            slot[tail] <= s_data;
            tail       <= ~tail;
         end
         if (winc) head <= ~head;
         cnt     <= cnt_next;
         s_ready <= (cnt_next != 2'd2);
      end
   end

   // ---------------- fill level ----------------
   // Modulo-2^PW subtraction of binary pointers stays correct across wrap.
   logic [PW-1:0] wb, rb, diff;

   assign wb   = gray2bin(wptr);
   assign rb   = gray2bin(wq2_rptr);
   assign diff = wb - rb;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wlevel       <= '0;
         walmost_full <= 1'b0;
      end else begin
         wlevel       <= diff;
         walmost_full <= (diff >= AF_LIM);
      end
   end

   // ---------------- statistics ----------------
`ifdef WFRONT_STATS_EN
   logic [15:0] stall_q, wr_q;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         stall_q <= '0;
         wr_q    <= '0;
      end else begin
         if (s_valid && !s_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
         if (winc && wr_q != 16'hFFFF)                   wr_q    <= wr_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
   assign wr_cnt    = wr_q;
`else
   assign stall_cnt = '0;
   assign wr_cnt    = '0;
`endif

endmodule

// File: tb/tb_wfifo_wr_front.sv
// Self-checking bench for wfifo_wr_front: queue-based reference model, directed
// scenarios and a randomized phase. Honours `WFRONT_STATS_EN for counter expectations.
module tb_wfifo_wr_front;

   localparam int DSIZE = 8;
   localparam int ADDRSIZE = 4;
   localparam int AF_THRESH = 12;
   localparam int MOD = 1 << (ADDRSIZE + 1);
`ifdef WFRONT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic                wclk = 1'b0;
   logic                wrst_n;
   logic                s_valid;
   logic [DSIZE-1:0]    s_data;
   logic                s_ready;
   logic                wfull;
   logic [ADDRSIZE:0]   wptr;
   logic [ADDRSIZE:0]   wq2_rptr;
   logic                winc;
   logic [DSIZE-1:0]    wdata;
   logic [ADDRSIZE:0]   wlevel;
   logic                walmost_full;
   logic [15:0]         stall_cnt;
   logic [15:0]         wr_cnt;

   wfifo_wr_front #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE), .AF_THRESH(AF_THRESH)) dut (
      .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .wfull(wfull), .wptr(wptr), .wq2_rptr(wq2_rptr), .winc(winc), .wdata(wdata),
      .wlevel(wlevel), .walmost_full(walmost_full), .stall_cnt(stall_cnt), .wr_cnt(wr_cnt)
   );

   always #5 wclk = ~wclk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [DSIZE-1:0] q[$];
   bit m_ready;
   int m_level;
   int m_stall, m_wr;
   int wb_i, rb_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [ADDRSIZE:0] to_gray(input int b);
      logic [ADDRSIZE:0] v;
      v = (ADDRSIZE+1)'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic set_ptr(input int w, input int r);
      wb_i = ((w % MOD) + MOD) % MOD;
      rb_i = ((r % MOD) + MOD) % MOD;
      wptr = to_gray(wb_i);
      wq2_rptr = to_gray(rb_i);
   endtask

   // Check outputs mid-cycle, then advance one clock and update the model.
   task automatic tick();
      bit acc, drn;
      int lvl_n;
      #2;
      drn = (q.size() != 0) && !wfull;
      acc = s_valid && m_ready;
      check("winc", 32'(winc), 32'(drn));
      if (drn) check("wdata", 32'(wdata), 32'(q[0]));
      check("s_ready", 32'(s_ready), 32'(m_ready));
      check("wlevel", 32'(wlevel), 32'(m_level));
      check("walmost_full", 32'(walmost_full), 32'(m_level >= AF_THRESH));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("wr_cnt", 32'(wr_cnt), 32'(m_wr));
      lvl_n = ((wb_i - rb_i) % MOD + MOD) % MOD;
      @(posedge wclk);
      #1;
      if (STATS && s_valid && !m_ready && m_stall < 65535) m_stall++;
      if (STATS && drn && m_wr < 65535) m_wr++;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(s_data);
      m_ready = (q.size() != 2);
      m_level = lvl_n;
   endtask

   task automatic do_reset();
      wrst_n = 1'b0;
      #1;
      check("rst_winc", 32'(winc), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_wlevel", 32'(wlevel), 32'd0);
      check("rst_walmost_full", 32'(walmost_full), 32'd0);
      check("rst_wdata", 32'(wdata), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
      q.delete();
      m_ready = 1'b0;
      m_level = 0;
      m_stall = 0;
      m_wr = 0;
      @(posedge wclk);
      #1;
      wrst_n = 1'b1;
   endtask

   // Hold a word on the stream until it is accepted, within a cycle budget.
   task automatic send(input logic [DSIZE-1:0] d);
      bit done = 1'b0;
      s_valid = 1'b1;
      s_data = d;
      for (int i = 0; i < 40 && !done; i++) begin
         done = m_ready;
         tick();
      end
      if (!done) check("send_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      wrst_n = 1'b0;
      s_valid = 1'b1;
      s_data = 8'h11;
      wfull = 1'b0;
      set_ptr(0, 0);
      do_reset();

      // basic stream
      send(8'h11);
      send(8'h22);
      send(8'h33);
      s_valid = 1'b0;
      repeat (3) tick();

      // continuous stream with wfull held for 5 cycles
      begin
         int k = 0;
         for (int i = 0; i < 20; i++) begin
            bit pre;
            s_valid = 1'b1;
            s_data = 8'h40 + 8'(k);
            wfull = (i >= 3 && i < 8);
            if (i == 7) begin
               #2;
               check("full_winc_low", 32'(winc), 32'd0);
               check("full_ready_low", 32'(s_ready), 32'd0);
            end
            pre = m_ready;
            tick();
            if (pre) k++;
         end
      end
      s_valid = 1'b0;
      wfull = 1'b0;
      repeat (3) tick();

      // level arithmetic, including pointer wrap
      set_ptr(20, 7);
      tick();
      #2;
      check("level_20_7", 32'(wlevel), 32'd13);
      check("af_20_7", 32'(walmost_full), 32'd1);
      set_ptr(2, 28);
      tick();
      #2;
      check("level_wrap", 32'(wlevel), 32'd6);
      check("af_wrap", 32'(walmost_full), 32'd0);
      set_ptr(28, 16);
      tick();
      #2;
      check("af_at_thresh", 32'(walmost_full), 32'd1);
      set_ptr(27, 16);
      tick();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         s_valid = 1'($urandom_range(0, 3) != 0);
         s_data = 8'($urandom);
         wfull = ($urandom_range(0, 9) < 3);
         if (i % 4 == 0) begin
            int w;
            w = $urandom_range(0, MOD - 1);
            set_ptr(w, w - int'($urandom_range(0, 1 << ADDRSIZE)));
         end
         tick();
      end

      // fill buffer to 2, then reset while winc is high
      wfull = 1'b1;
      s_valid = 1'b1;
      set_ptr(9, 1);
      for (int i = 0; i < 10 && q.size() != 2; i++) begin
         s_data = 8'hC0 + 8'(i);
         tick();
      end
      check("mid_cnt2", 32'(q.size()), 32'd2);
      tick();
      s_valid = 1'b0;
      wfull = 1'b0;
      #2;
      check("pre_rst_winc", 32'(winc), 32'd1);
      do_reset();
      send(8'hA5);
      send(8'h5A);
      s_valid = 1'b0;
      repeat (3) tick();

      // statistics
      s_valid = 1'b1;
      wfull = 1'b1;
      s_data = 8'h77;
      if (STATS) begin
         repeat (70000) tick();
         #2;
         check("stall_sat", 32'(stall_cnt), 32'h0000FFFF);
      end else begin
         repeat (30) tick();
         #2;
         check("stall_off", 32'(stall_cnt), 32'd0);
         check("wr_off", 32'(wr_cnt), 32'd0);
      end
      s_valid = 1'b0;
      wfull = 1'b0;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
